// File: rtl/char_motion_ctl.sv
// char_motion_ctl
//   Per-frame motion controller for the player sprite. Button inputs are
//   already synchronous and debounced. The frame tick is the rising edge of
//   vblnk. On each tick the sprite centre (pos_x, pos_y) takes one horizontal
//   step and one step of the vertical jump/gravity FSM. All outputs are
//   registered, so they hold steady for the rest of the frame.
//
//   Optional feature: define DOUBLE_JUMP_EN to allow one extra jump while
//   airborne. The extra jump is re-armed on landing.

module char_motion_ctl #(
  parameter int SCREEN_W      = 800,
  parameter int SCREEN_H      = 600,
  parameter int GROUND_MARGIN = 50,
  parameter int CHAR_HGT      = 26,
  parameter int CHAR_LNG      = 19,
  parameter int MOVE_STEP     = 3,
  parameter int JUMP_V0       = 12,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        flip_h,
  output logic        on_ground
);

  // state  | meaning
  // GROUND | standing on the ground line, waiting for a jump request
  // RISE   | moving up; velocity drops by GRAVITY each frame
  // FALL   | moving down; velocity grows up to MAX_FALL until landing

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  localparam logic [11:0]        X_RST   = 12'(SCREEN_W / 2);
  localparam logic [11:0]        Y_GND   = 12'(SCREEN_H - GROUND_MARGIN - CHAR_HGT);
  localparam logic [11:0]        Y_TOP   = 12'(CHAR_HGT);
  localparam logic signed [12:0] X_MIN_S = 13'(CHAR_LNG);
  localparam logic signed [12:0] X_MAX_S = 13'(SCREEN_W - 1 - CHAR_LNG);
  localparam logic signed [12:0] Y_TOP_S = 13'(CHAR_HGT);
  localparam logic signed [12:0] Y_GND_S = 13'(SCREEN_H - GROUND_MARGIN - CHAR_HGT);
  localparam logic signed [12:0] STEP_S  = 13'(MOVE_STEP);
  localparam logic [5:0]         V0      = 6'(JUMP_V0);
  localparam logic [5:0]         GRAV    = 6'(GRAVITY);
  localparam logic [5:0]         VMAX    = 6'(MAX_FALL);

  logic        vblnk_q;
  logic        btn_jump_q;
  logic        jump_pend;
  logic        tick;
  logic        jump_edge;
  logic        jump_req;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  vel;
  logic [5:0]  vel_nx;
  logic [11:0] x_nx;
  logic [11:0] y_nx;
  logic        flip_nx;

  logic signed [12:0] x_try;
  logic signed [12:0] y_try;
  logic [6:0]         vel_up;
  logic [5:0]         vel_fall;

`ifdef DOUBLE_JUMP_EN
  logic air_jump_used;
  logic air_used_nx;
`endif

  assign tick      = vblnk & ~vblnk_q;
  assign jump_edge = btn_jump & ~btn_jump_q;
  // A button edge that lands on the tick clock counts for that tick.
  assign jump_req  = jump_pend | jump_edge;

  // Edge detectors plus the latch that holds a jump request until the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q    <= 1'b0;
      btn_jump_q <= 1'b0;
      jump_pend  <= 1'b0;
    end else begin
      vblnk_q    <= vblnk;
      btn_jump_q <= btn_jump;
      if (tick)
        jump_pend <= 1'b0;
      else if (jump_edge)
        jump_pend <= 1'b1;
    end
  end

  // Horizontal step. The sum is widened to 13-bit signed so it cannot wrap before the clamp.
  always_comb begin
    x_try   = $signed({1'b0, pos_x});
    flip_nx = flip_h;
    if (btn_left && !btn_right) begin
      x_try   = x_try - STEP_S;
      flip_nx = 1'b1;
    end else if (btn_right && !btn_left) begin
      x_try   = x_try + STEP_S;
      flip_nx = 1'b0;
    end
    if (x_try < X_MIN_S)
      x_nx = X_MIN_S[11:0];
    else if (x_try > X_MAX_S)
      x_nx = X_MAX_S[11:0];
    else
      x_nx = x_try[11:0];
  end

  // Next state of the vertical FSM, velocity and y for the coming tick.
  always_comb begin
    state_nx = state;
    vel_nx   = vel;
    y_nx     = pos_y;
    y_try    = $signed({1'b0, pos_y});
    vel_up   = {1'b0, vel} + {1'b0, GRAV};
    vel_fall = (vel_up > {1'b0, VMAX}) ? VMAX : vel_up[5:0];
`ifdef DOUBLE_JUMP_EN
    air_used_nx = air_jump_used;
`endif
    case (state)
      ST_GROUND: begin
        if (jump_req) begin
          state_nx = ST_RISE;
          vel_nx   = V0;
        end
      end
      ST_RISE: begin
`ifdef DOUBLE_JUMP_EN
        if (jump_req && !air_jump_used) begin
          state_nx    = ST_RISE;
          vel_nx      = V0;
          air_used_nx = 1'b1;
        end else
`endif
        begin
          y_try = $signed({1'b0, pos_y}) - $signed({7'b0, vel});
          if (y_try < Y_TOP_S) begin
            // Hit the top of the screen: stop rising and start to fall.
            y_nx     = Y_TOP;
            vel_nx   = 6'd0;
            state_nx = ST_FALL;
          end else begin
            y_nx = y_try[11:0];
            if (vel <= GRAV) begin
              vel_nx   = 6'd0;
              state_nx = ST_FALL;
            end else begin
              vel_nx = vel - GRAV;
            end
          end
        end
      end
      ST_FALL: begin
`ifdef DOUBLE_JUMP_EN
        if (jump_req && !air_jump_used) begin
          state_nx    = ST_RISE;
          vel_nx      = V0;
          air_used_nx = 1'b1;
        end else
`endif
        begin
          y_try = $signed({1'b0, pos_y}) + $signed({7'b0, vel_fall});
          if (y_try >= Y_GND_S) begin
            y_nx     = Y_GND;
            vel_nx   = 6'd0;
            state_nx = ST_GROUND;
`ifdef DOUBLE_JUMP_EN
            air_used_nx = 1'b0;
`endif
          end else begin
            y_nx   = y_try[11:0];
            vel_nx = vel_fall;
          end
        end
      end
      default: begin
        // Illegal encoding: recover by putting the sprite back on the ground.
        state_nx = ST_GROUND;
        vel_nx   = 6'd0;
        y_nx     = Y_GND;
`ifdef DOUBLE_JUMP_EN
        air_used_nx = 1'b0;
`endif
      end
    endcase
  end

  // Motion FSM and output registers. They update only on the frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_GROUND;
      vel       <= 6'd0;
      pos_x     <= X_RST;
      pos_y     <= Y_GND;
      flip_h    <= 1'b0;
      on_ground <= 1'b1;
`ifdef DOUBLE_JUMP_EN
      air_jump_used <= 1'b0;
`endif
    end else if (tick) begin
      state     <= state_nx;
      vel       <= vel_nx;
      pos_x     <= x_nx;
      pos_y     <= y_nx;
      flip_h    <= flip_nx;
      on_ground <= (state_nx == ST_GROUND);
`ifdef DOUBLE_JUMP_EN
      air_jump_used <= air_used_nx;
`endif
    end
  end

endmodule

// File: tb/tb_char_motion_ctl.sv
// tb_char_motion_ctl
//   Scoreboard bench for char_motion_ctl (default build). The stimulus
//   process pushes the expected outputs for each frame tick. A monitor pops
//   that entry and compares it after the tick's clock edge.

module tb_char_motion_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblnk;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  logic        flip_h;
  logic        on_ground;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   x;
    int   y;
    logic f;
    logic g;
  } exp_t;

  exp_t sb[$];

  // Model state for the expected values.
  int   ex;
  logic ef;
  int   phase;  // -1 = on ground, otherwise index into jump_y
  int   jump_y [25];

  char_motion_ctl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk     (vblnk),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .flip_h    (flip_h),
    .on_ground (on_ground)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each vblnk rise produces one tick. Compare after that clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge vblnk);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: tick with no expected entry, got x=%0d y=%0d", pos_x, pos_y);
      end else begin
        e = sb.pop_front();
        check("pos_x",     32'(pos_x),     32'(e.x));
        check("pos_y",     32'(pos_y),     32'(e.y));
        check("flip_h",    32'(flip_h),    32'(e.f));
        check("on_ground", 32'(on_ground), 32'(e.g));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  // jm: 0 = leave btn_jump alone, 1 = one-clock pulse mid-frame,
  //     2 = raise btn_jump together with vblnk (and keep it held).
  task automatic frame(input logic l, input logic r, input int jm);
    exp_t e;
    bit   req;
    btn_left  = l;
    btn_right = r;
    @(negedge clk) vblnk = 1'b0;
    repeat (2) @(negedge clk);
    if (jm == 1) begin
      btn_jump = 1'b1;
      @(negedge clk) btn_jump = 1'b0;
    end
    repeat (2) @(negedge clk);
    req = (jm == 1) || (jm == 2);
    if (l && !r) begin
      ex = (ex - 3 < 19) ? 19 : ex - 3;
      ef = 1'b1;
    end else if (r && !l) begin
      ex = (ex + 3 > 780) ? 780 : ex + 3;
      ef = 1'b0;
    end
    if (phase < 0 && req) phase = 0;
    e.x = ex;
    e.f = ef;
    if (phase >= 0) begin
      e.y = jump_y[phase];
      e.g = (phase == 24);
      phase++;
      if (phase == 25) phase = -1;
    end else begin
      e.y = 524;
      e.g = 1'b1;
    end
    sb.push_back(e);
    if (jm == 2) btn_jump = 1'b1;
    vblnk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Assert reset and check the reset values 1 ns later, with no clock edge in between.
  task automatic do_reset();
    vblnk     = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_jump  = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_pos_x",     32'(pos_x),     32'd400);
    check("rst_pos_y",     32'(pos_y),     32'd524);
    check("rst_flip_h",    32'(flip_h),    32'd0);
    check("rst_on_ground", 32'(on_ground), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ex    = 400;
    ef    = 1'b0;
    phase = -1;
  endtask

  initial begin
    // Default jump profile, worked out by hand: launch, 12 rising ticks, 12 falling ticks.
    jump_y = '{524, 512, 501, 491, 482, 474, 467, 461, 456, 452, 449, 447, 446,
               447, 449, 452, 456, 461, 467, 474, 482, 491, 501, 512, 524};
    vblnk = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    rst_n = 1'b1;
    ex = 400; ef = 1'b0; phase = -1;
    #2;
    do_reset();

    // 1: idle frames
    repeat (5) frame(1'b0, 1'b0, 0);

    // 2: walk left into the left clamp
    repeat (130) frame(1'b1, 1'b0, 0);
    frame(1'b0, 1'b0, 0);

    // 3: walk right from centre into the right clamp, then both / neither pressed
    do_reset();
    repeat (130) frame(1'b0, 1'b1, 0);
    repeat (3) frame(1'b1, 1'b1, 0);
    repeat (2) frame(1'b0, 1'b0, 0);
    frame(1'b1, 1'b0, 0);
    repeat (2) frame(1'b1, 1'b1, 0);

    // 4: one-clock jump pulse mid-frame, full jump tracked tick by tick
    do_reset();
    frame(1'b0, 1'b0, 1);
    repeat (26) frame(1'b0, 1'b0, 0);

    // 5: jump edge coincident with the tick, button then held for 40 more ticks
    frame(1'b0, 1'b0, 2);
    repeat (40) frame(1'b0, 1'b0, 0);
    btn_jump = 1'b0;
    repeat (2) frame(1'b0, 1'b0, 0);

    // Air press in FALL is discarded in the default build; walk right during the jump
    frame(1'b0, 1'b1, 1);
    repeat (16) frame(1'b0, 1'b1, 0);
    frame(1'b0, 1'b0, 1);
    repeat (10) frame(1'b1, 1'b0, 0);
    repeat (2) frame(1'b0, 1'b0, 0);

    // 6: reset during RISE while facing left
    frame(1'b1, 1'b0, 1);
    repeat (4) frame(1'b1, 1'b0, 0);
    do_reset();
    repeat (2) frame(1'b0, 1'b0, 0);

    // A jump request latched just before reset must not survive it
    @(negedge clk) btn_jump = 1'b1;
    @(negedge clk) btn_jump = 1'b0;
    do_reset();
    repeat (3) frame(1'b0, 1'b0, 0);

    repeat (4) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
